// File: rtl/framebuffer_avn_arbiter.sv
// Shares one SRAM Avalon-MM slave between the VGA prefetch reader (m0) and the pixel writer (m1).
// Reads win by default; a starvation counter forces the writer through after WR_MAX_WAIT blocked cycles.
module framebuffer_avn_arbiter #(
    parameter int AVN_AW      = 18,
    parameter int AVN_DW      = 16,
    parameter int WR_MAX_WAIT = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  m0_avn_read,
    input  logic [AVN_AW-1:0]     m0_avn_address,
    output logic                  m0_avn_waitrequest,
    output logic [AVN_DW-1:0]     m0_avn_readdata,
    output logic                  m0_avn_readdatavalid,
    input  logic                  m1_avn_write,
    input  logic [AVN_AW-1:0]     m1_avn_address,
    input  logic [AVN_DW-1:0]     m1_avn_writedata,
    input  logic [AVN_DW/8-1:0]   m1_avn_byteenable,
    output logic                  m1_avn_waitrequest,
    output logic                  s_avn_read,
    output logic                  s_avn_write,
    output logic [AVN_AW-1:0]     s_avn_address,
    output logic [AVN_DW-1:0]     s_avn_writedata,
    output logic [AVN_DW/8-1:0]   s_avn_byteenable,
    input  logic                  s_avn_waitrequest,
    input  logic [AVN_DW-1:0]     s_avn_readdata,
    input  logic                  s_avn_readdatavalid
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, TURN = 2'd3} state_t;

    state_t     state, state_nxt;
    logic [7:0] wr_wait;
    logic       cmd_busy, retire, can_load, force_wr;
    logic       read_grant, write_grant;

    assign cmd_busy = s_avn_read | s_avn_write;
    assign retire   = cmd_busy & ~s_avn_waitrequest;
    assign can_load = ~cmd_busy | retire;
    assign force_wr = (wr_wait == 8'(WR_MAX_WAIT));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        read_grant  = 1'b0;
        write_grant = 1'b0;
        case (state)
            IDLE: begin
                if (m1_avn_write && (force_wr || !m0_avn_read)) begin
                    write_grant = 1'b1;
                    state_nxt   = WR;
                end else if (m0_avn_read) begin
                    read_grant = 1'b1;
                    state_nxt  = RD;
                end
            end
            RD: begin
                if (m0_avn_read && !force_wr && can_load)
                    read_grant = 1'b1;
                else if (m1_avn_write && can_load)
                    state_nxt = TURN;
                else if (!m0_avn_read && !m1_avn_write && !cmd_busy)
                    state_nxt = IDLE;
            end
            WR: begin
                if (m1_avn_write && (force_wr || !m0_avn_read) && can_load)
                    write_grant = 1'b1;
                else if (m0_avn_read && can_load)
                    state_nxt = TURN;
                else if (!m0_avn_read && !m1_avn_write && !cmd_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // No master may be accepted while reset is held.
        if (!sys_rst) begin
            read_grant  = 1'b0;
            write_grant = 1'b0;
        end
    end

    always_comb begin
        m0_avn_waitrequest = ~read_grant;
        m1_avn_waitrequest = ~write_grant;
    end

    // Command register: contents stay frozen while the slave stalls.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            s_avn_read       <= 1'b0;
            s_avn_write      <= 1'b0;
            s_avn_address    <= '0;
            s_avn_writedata  <= '0;
            s_avn_byteenable <= '0;
        end else if (read_grant) begin
            s_avn_read       <= 1'b1;
            s_avn_write      <= 1'b0;
            s_avn_address    <= m0_avn_address;
            s_avn_byteenable <= '1;
        end else if (write_grant) begin
            s_avn_read       <= 1'b0;
            s_avn_write      <= 1'b1;
            s_avn_address    <= m1_avn_address;
            s_avn_writedata  <= m1_avn_writedata;
            s_avn_byteenable <= m1_avn_byteenable;
        end else if (retire) begin
            s_avn_read  <= 1'b0;
            s_avn_write <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            wr_wait <= '0;
        else if (write_grant || !m1_avn_write)
            wr_wait <= '0;
        else if (!force_wr)
            wr_wait <= wr_wait + 8'd1;
    end

    // Read return path: only reads ever return data, so order alone identifies them.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            m0_avn_readdatavalid <= 1'b0;
            m0_avn_readdata      <= '0;
        end else begin
            m0_avn_readdatavalid <= s_avn_readdatavalid;
            m0_avn_readdata      <= s_avn_readdata;
        end
    end

endmodule

// File: tb/tb_framebuffer_avn_arbiter.sv
// Directed bench for framebuffer_avn_arbiter with a fixed-latency (2 cycle) SRAM slave model.
module tb_framebuffer_avn_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_read = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic          m0_wait;
    logic [DW-1:0] m0_rdata;
    logic          m0_rdv;
    logic          m1_write = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [1:0]    m1_be = 2'b11;
    logic          m1_wait;
    logic          s_read, s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [1:0]    s_be;
    logic          s_wait = 1'b0;
    logic [DW-1:0] s_rdata;
    logic          s_rdv;

    framebuffer_avn_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .WR_MAX_WAIT(8)) dut (
        .sys_clk(clk), .sys_rst(rst_n),
        .m0_avn_read(m0_read), .m0_avn_address(m0_addr), .m0_avn_waitrequest(m0_wait),
        .m0_avn_readdata(m0_rdata), .m0_avn_readdatavalid(m0_rdv),
        .m1_avn_write(m1_write), .m1_avn_address(m1_addr), .m1_avn_writedata(m1_wdata),
        .m1_avn_byteenable(m1_be), .m1_avn_waitrequest(m1_wait),
        .s_avn_read(s_read), .s_avn_write(s_write), .s_avn_address(s_addr),
        .s_avn_writedata(s_wdata), .s_avn_byteenable(s_be), .s_avn_waitrequest(s_wait),
        .s_avn_readdata(s_rdata), .s_avn_readdatavalid(s_rdv)
    );

    always #5 clk = ~clk;

    // Slave model: data = 0xC300 ^ address, valid two cycles after acceptance.
    logic          p1 = 1'b0, p2 = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        p1 <= s_read && !s_wait;
        a1 <= s_addr;
        p2 <= p1;
        a2 <= a1;
    end
    assign s_rdv   = p2;
    assign s_rdata = 16'hC300 ^ a2[15:0];

    int cyc = 0;
    int both_hi = 0;
    int iss_q[$];
    int iss_a[$];
    int rdv_q[$];
    int rdv_d[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (s_read && s_write) both_hi++;
        if (s_read && !s_wait) begin
            iss_q.push_back(cyc);
            iss_a.push_back(int'(s_addr));
        end
        if (m0_rdv) begin
            rdv_q.push_back(cyc);
            rdv_d.push_back(int'(m0_rdata));
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state, with a read request pending to show it is not accepted
        m0_read = 1'b1;
        #3;
        check("rst_s_read", 32'(s_read), 0);
        check("rst_s_write", 32'(s_write), 0);
        check("rst_s_addr", 32'(s_addr), 0);
        check("rst_s_wdata", 32'(s_wdata), 0);
        check("rst_m0_rdv", 32'(m0_rdv), 0);
        check("rst_m0_wait", 32'(m0_wait), 1);
        check("rst_m1_wait", 32'(m1_wait), 1);
        check("rst_state", 32'(dut.state), 0);
        check("rst_wr_wait", 32'(dut.wr_wait), 0);
        m0_read = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write from IDLE
        m1_write = 1'b1; m1_addr = 18'h00010; m1_wdata = 16'h0ABC; m1_be = 2'b11;
        #2;
        check("wr1_m1_wait", 32'(m1_wait), 0);
        check("wr1_m0_wait", 32'(m0_wait), 1);
        step();
        m1_write = 1'b0;
        check("wr1_s_write", 32'(s_write), 1);
        check("wr1_s_read", 32'(s_read), 0);
        check("wr1_s_addr", 32'(s_addr), 32'h10);
        check("wr1_s_wdata", 32'(s_wdata), 32'h0ABC);
        step();
        check("wr1_retired", 32'(s_write), 0);
        step();
        check("wr1_idle", 32'(dut.state), 0);

        // Back-to-back reads at addresses 0..3
        iss_q.delete(); iss_a.delete(); rdv_q.delete(); rdv_d.delete();
        for (int i = 0; i < 4; i++) begin
            m0_read = 1'b1; m0_addr = 18'(i);
            #2;
            check("b2b_m0_wait", 32'(m0_wait), 0);
            step();
            check("b2b_s_read", 32'(s_read), 1);
            check("b2b_s_addr", 32'(s_addr), 32'(i));
            check("b2b_state_rd", 32'(dut.state), 1);
        end
        m0_read = 1'b0;
        repeat (6) step();
        check("b2b_issues", 32'(iss_q.size()), 4);
        check("b2b_returns", 32'(rdv_q.size()), 4);
        for (int i = 0; i < 4 && i < iss_q.size() && i < rdv_q.size(); i++) begin
            check("b2b_issue_addr", 32'(iss_a[i]), 32'(i));
            check("b2b_issue_cyc", 32'(iss_q[i] - iss_q[0]), 32'(i));
            check("b2b_latency", 32'(rdv_q[i] - iss_q[i]), 3);
            check("b2b_rdata", 32'(rdv_d[i]), 32'hC300 ^ 32'(i));
        end
        check("b2b_idle", 32'(dut.state), 0);

        // Direction switch: read at 5 then write at 6
        m0_read = 1'b1; m0_addr = 18'd5;
        #2;
        check("sw_rd_grant", 32'(m0_wait), 0);
        step();
        m0_read = 1'b0; m1_write = 1'b1; m1_addr = 18'd6; m1_wdata = 16'h6666;
        #2;
        check("sw_s_read", 32'(s_read), 1);
        check("sw_m1_wait_rd", 32'(m1_wait), 1);
        step();
        check("sw_turn_state", 32'(dut.state), 3);
        check("sw_turn_idle_bus", 32'({s_read, s_write}), 0);
        check("sw_turn_m1_wait", 32'(m1_wait), 1);
        step();
        check("sw_wr_grant", 32'(m1_wait), 0);
        step();
        m1_write = 1'b0;
        check("sw_s_write", 32'(s_write), 1);
        check("sw_s_addr", 32'(s_addr), 6);
        repeat (3) step();

        // Starvation: continuous reads, pending write forced after 8 blocked cycles
        m0_read = 1'b1; m0_addr = 18'h40;
        m1_write = 1'b1; m1_addr = 18'h80; m1_wdata = 16'h8888;
        #1;
        check("both_rd_wins", 32'(m0_wait), 0);
        check("both_wr_held", 32'(m1_wait), 1);
        n = 0;
        while (m1_wait && n < 40) begin
            step();
            n++;
        end
        check("starve_grant_cycle", 32'(n), 10);
        check("starve_wr_wait_max", 32'(dut.wr_wait), 8);
        check("starve_m0_blocked", 32'(m0_wait), 1);
        step();
        m1_write = 1'b0; m0_read = 1'b0;
        check("starve_s_write", 32'(s_write), 1);
        check("starve_s_addr", 32'(s_addr), 32'h80);
        check("starve_wr_wait_clr", 32'(dut.wr_wait), 0);
        repeat (4) step();

        // Slave stall on a held write
        m1_write = 1'b1; m1_addr = 18'h20; m1_wdata = 16'h1111; m1_be = 2'b01;
        #1;
        check("stall_first_grant", 32'(m1_wait), 0);
        step();
        m1_addr = 18'h21; m1_wdata = 16'h2222; s_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_s_write", 32'(s_write), 1);
            check("stall_s_addr", 32'(s_addr), 32'h20);
            check("stall_s_wdata", 32'(s_wdata), 32'h1111);
            check("stall_m1_wait", 32'(m1_wait), 1);
            step();
        end
        s_wait = 1'b0;
        #1;
        check("stall_retire_grant", 32'(m1_wait), 0);
        step();
        m1_write = 1'b0;
        check("stall_next_addr", 32'(s_addr), 32'h21);
        check("stall_next_wdata", 32'(s_wdata), 32'h2222);
        check("stall_next_be", 32'(s_be), 32'h1);
        repeat (3) step();

        // Async reset during a stalled read
        m0_read = 1'b1; m0_addr = 18'h33; m1_write = 1'b1;
        #1;
        check("ar_rd_grant", 32'(m0_wait), 0);
        step();
        s_wait = 1'b1;
        step();
        check("ar_s_read_held", 32'(s_read), 1);
        check("ar_wr_wait_pre", 32'(dut.wr_wait), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_s_read", 32'(s_read), 0);
        check("ar_state", 32'(dut.state), 0);
        check("ar_wr_wait", 32'(dut.wr_wait), 0);
        check("ar_m0_wait", 32'(m0_wait), 1);
        check("ar_m1_wait", 32'(m1_wait), 1);
        m0_read = 1'b0; m1_write = 1'b0; s_wait = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        check("never_rd_and_wr", 32'(both_hi), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/framebuffer_avn_arbiter.md
Name: framebuffer_avn_arbiter

Overview:
- Shares one SRAM Avalon-MM slave port between two masters.
  - Master 0: the VGA line-prefetch reader, read-only.
  - Master 1: the video daisy pipeline pixel writer, write-only.
- Sits in sys_clk domain between the video pipeline / VGA read path and the SRAM Avalon controller.
- Registers the granted command toward the slave.
- Inserts one bus-turnaround cycle on every read/write direction change.
- Reads have priority; a starvation counter guarantees the writer forward progress.

Parameters:
AVN_AW, 18, Avalon word-address width
AVN_DW, 16, Avalon data width (must be multiple of 8)
WR_MAX_WAIT, 8, cycles a pending write may be blocked by reads before it is forced to win (range 1..255)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-low reset
m0_avn_read  in  1  prefetcher read request
m0_avn_address  in  AVN_AW  prefetcher address
m0_avn_waitrequest  out  1  read not accepted this cycle
m0_avn_readdata  out  AVN_DW  returned read data
m0_avn_readdatavalid  out  1  m0_avn_readdata valid
m1_avn_write  in  1  pixel write request
m1_avn_address  in  AVN_AW  pixel address
m1_avn_writedata  in  AVN_DW  pixel data
m1_avn_byteenable  in  AVN_DW/8  byte enables
m1_avn_waitrequest  out  1  write not accepted this cycle
s_avn_read  out  1  slave read command
s_avn_write  out  1  slave write command
s_avn_address  out  AVN_AW  slave address
s_avn_writedata  out  AVN_DW  slave write data
s_avn_byteenable  out  AVN_DW/8  slave byte enables (all ones for reads)
s_avn_waitrequest  in  1  slave stall
s_avn_readdata  in  AVN_DW  slave read data
s_avn_readdatavalid  in  1  slave read data valid

Behaviour:
- Reset (sys_rst=0, async) sets:
  - state=IDLE, cmd register empty.
  - s_avn_read/write=0; s_avn_address/writedata/byteenable=0.
  - m0_avn_readdatavalid=0, m0_avn_readdata=0, wr_wait=0.
  - m0/m1 waitrequest=1 while in reset.
- Command register: s_avn_* outputs are registered. A held command (read or write =1) is retired in the cycle s_avn_waitrequest=0. Address and data stay stable while stalled.
- can_load = cmd register empty OR held command retiring this cycle.
- States:
  - IDLE: cmd empty.
  - RD: last loaded command was a read.
  - WR: last loaded command was a write.
  - TURN: one dead cycle, no command issued.
- Grant, evaluated combinationally each cycle:
  - force_wr = (wr_wait == WR_MAX_WAIT).
  - IDLE:
    - m1_avn_write & (force_wr | !m0_avn_read): grant write, load, ->WR.
    - else m0_avn_read: grant read, load, ->RD.
  - RD:
    - m0_avn_read & !force_wr & can_load: grant read (back-to-back allowed).
    - else if m1_avn_write and the held read retires (or none is held): ->TURN.
    - else if no requests and cmd empty: ->IDLE.
  - WR: symmetric with RD. Direction change requires m0_avn_read & !force_wr, or m1 idle.
  - TURN: no grant; ->IDLE next cycle.
- Master waitrequest: m0_avn_waitrequest = !read_grant; m1_avn_waitrequest = !write_grant. A master's request is consumed in the cycle its waitrequest=0; the command appears on s_avn_* the next cycle.
- Starvation counter wr_wait:
  - Increments (saturating at WR_MAX_WAIT) each cycle m1_avn_write=1 and write_grant=0.
  - Clears on write_grant.
  - Held at 0 when m1_avn_write=0.
- Read return: m0_avn_readdatavalid/readdata = s_avn_readdatavalid/readdata, registered, +1 cycle. Order is preserved; no tagging, since the writer never reads.
- Simultaneous request in IDLE with wr_wait < WR_MAX_WAIT: read wins.
- Slave stall with a new same-direction request: the new request is held off (waitrequest=1) until retire.
- Reset mid-transaction: held command is dropped; outputs return to reset values immediately.

Test Plan:
- Single write from IDLE: m1 write addr 0x00010, data 0x0ABC, s_waitrequest=0.
  - m1_waitrequest=0 in cycle 0.
  - s_avn_write=1, addr 0x00010, data 0x0ABC in cycle 1.
  - Idle afterwards.
- Back-to-back reads: 4 reads at addr 0..3 with slave readdatavalid at fixed latency 2.
  - One read issued per cycle, no TURN.
  - m0_readdatavalid pulses 4 times, in order, 3 cycles after each issue.
- Direction switch: read at 5 followed by write at 6.
  - s_avn_read cycle 1, TURN cycle 2, s_avn_write cycle 3 or later.
  - Never read and write high in the same cycle.
- Starvation, WR_MAX_WAIT=8: m0 reads continuous, m1 write pending.
  - Write granted once wr_wait reaches 8: TURN, then s_avn_write.
  - wr_wait returns to 0 after the grant.
- Slave stall: s_waitrequest=1 for 3 cycles on a held write.
  - s_avn_* are stable for those cycles.
  - m1_waitrequest=1 for the next write until the held write retires.
- Async reset asserted mid-read stall: s_avn_read drops to 0 without a clock edge; state returns to IDLE; wr_wait=0.
